// File: rtl/voting_session_ctrl.sv
// Ballot session controller: opens a session, accepts one vote per voter,
// then scans the tallies sequentially to report the winner or a tie.
module voting_session_ctrl #(
    parameter int N_VOTERS = 4,
    parameter int N_CAND   = 3,
    parameter int VID_W    = $clog2(N_VOTERS),
    parameter int CID_W    = $clog2(N_CAND),
    parameter int CNT_W    = $clog2(N_VOTERS + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    open_i,
    input  logic                    close_i,
    input  logic                    vote_valid_i,
    input  logic [VID_W-1:0]        vote_voter_i,
    input  logic [CID_W-1:0]        vote_cand_i,
    output logic                    accept_o,
    output logic                    reject_o,
    output logic                    busy_o,
    output logic                    done_o,
    output logic [CID_W-1:0]        winner_o,
    output logic                    tie_o,
    output logic [N_CAND*CNT_W-1:0] tally_o
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OPEN  = 2'd1,
        ST_TALLY = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic [VID_W:0]   VOTER_LIMIT = (VID_W + 1)'(N_VOTERS);
    localparam logic [CID_W:0]   CAND_LIMIT  = (CID_W + 1)'(N_CAND);
    localparam logic [CID_W-1:0] LAST_IDX    = CID_W'(N_CAND - 1);

    state_e                    state_q, state_d;
    logic [N_VOTERS-1:0]       mask_q, mask_d;
    logic [N_CAND*CNT_W-1:0]   tally_q, tally_d;
    logic [CID_W-1:0]          scan_idx_q, scan_idx_d;
    logic [CID_W-1:0]          max_idx_q, max_idx_d;
    logic [CNT_W-1:0]          max_cnt_q, max_cnt_d;
    logic                      dup_q, dup_d;
    logic [CID_W-1:0]          winner_q, winner_d;
    logic                      tie_q, tie_d;
    logic                      accept_q, accept_d;
    logic                      reject_q, reject_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      voted_s;
    logic                      vote_ok_s;
    logic [CNT_W-1:0]          scan_cnt_s;

    // Mux-free lookups so out-of-range IDs never index past the arrays
    always_comb begin
        voted_s    = 1'b0;
        scan_cnt_s = '0;
        for (int v = 0; v < N_VOTERS; v++) begin
            voted_s = voted_s | (mask_q[v] & (vote_voter_i == VID_W'(v)));
        end
        for (int k = 0; k < N_CAND; k++) begin
            scan_cnt_s = scan_cnt_s |
                         (tally_q[k*CNT_W +: CNT_W] & {CNT_W{scan_idx_q == CID_W'(k)}});
        end
        vote_ok_s = ({1'b0, vote_voter_i} < VOTER_LIMIT) && !voted_s &&
                    ({1'b0, vote_cand_i} < CAND_LIMIT);
    end

    // Session FSM: next state, vote bookkeeping and tally scan
    always_comb begin
        state_d    = state_q;
        mask_d     = mask_q;
        tally_d    = tally_q;
        scan_idx_d = scan_idx_q;
        max_idx_d  = max_idx_q;
        max_cnt_d  = max_cnt_q;
        dup_d      = dup_q;
        winner_d   = winner_q;
        tie_d      = tie_q;
        accept_d   = 1'b0;
        reject_d   = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                reject_d = vote_valid_i;
                if (open_i) begin
                    state_d  = ST_OPEN;
                    mask_d   = '0;
                    tally_d  = '0;
                    winner_d = '0;
                    tie_d    = 1'b0;
                end else begin
                    state_d = state_q;
                end
            end
            ST_OPEN: begin
                if (vote_valid_i && vote_ok_s) begin
                    accept_d = 1'b1;
                    for (int v = 0; v < N_VOTERS; v++) begin
                        mask_d[v] = mask_q[v] | (vote_voter_i == VID_W'(v));
                    end
                    for (int k = 0; k < N_CAND; k++) begin
                        if (vote_cand_i == CID_W'(k)) begin
                            tally_d[k*CNT_W +: CNT_W] = tally_q[k*CNT_W +: CNT_W] + CNT_W'(1);
                        end else begin
                            tally_d[k*CNT_W +: CNT_W] = tally_q[k*CNT_W +: CNT_W];
                        end
                    end
                end else begin
                    reject_d = vote_valid_i;
                end
                // A vote coincident with close is counted before the scan begins
                if (close_i) begin
                    state_d    = ST_TALLY;
                    scan_idx_d = '0;
                    max_idx_d  = '0;
                    max_cnt_d  = '0;
                    dup_d      = 1'b0;
                end else begin
                    state_d = ST_OPEN;
                end
            end
            ST_TALLY: begin
                reject_d = vote_valid_i;
                // Strictly-greater keeps the lowest index; a zero first count marks a tie
                if (scan_cnt_s > max_cnt_q) begin
                    max_cnt_d = scan_cnt_s;
                    max_idx_d = scan_idx_q;
                    dup_d     = 1'b0;
                end else if (scan_cnt_s == max_cnt_q) begin
                    dup_d = 1'b1;
                end else begin
                    dup_d = dup_q;
                end
                if (scan_idx_q == LAST_IDX) begin
                    state_d  = ST_DONE;
                    winner_d = max_idx_d;
                    tie_d    = dup_d;
                end else begin
                    scan_idx_d = scan_idx_q + CID_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d == ST_OPEN) || (state_d == ST_TALLY);
        done_d = (state_d == ST_DONE);
    end

    // State and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            mask_q     <= '0;
            tally_q    <= '0;
            scan_idx_q <= '0;
            max_idx_q  <= '0;
            max_cnt_q  <= '0;
            dup_q      <= 1'b0;
            winner_q   <= '0;
            tie_q      <= 1'b0;
            accept_q   <= 1'b0;
            reject_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mask_q     <= mask_d;
            tally_q    <= tally_d;
            scan_idx_q <= scan_idx_d;
            max_idx_q  <= max_idx_d;
            max_cnt_q  <= max_cnt_d;
            dup_q      <= dup_d;
            winner_q   <= winner_d;
            tie_q      <= tie_d;
            accept_q   <= accept_d;
            reject_q   <= reject_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign accept_o = accept_q;
    assign reject_o = reject_q;
    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign winner_o = winner_q;
    assign tie_o    = tie_q;
    assign tally_o  = tally_q;

endmodule

// File: tb/tb_voting_session_ctrl.sv
// Self-checking bench for voting_session_ctrl: directed scenarios plus random
// sessions compared against a ballot-level reference model.
module tb_voting_session_ctrl;

    localparam int NV = 4;
    localparam int NC = 3;
    localparam int VW = 2;
    localparam int CW = 2;
    localparam int TW = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             open_i = 1'b0;
    logic             close_i = 1'b0;
    logic             vote_valid_i = 1'b0;
    logic [VW-1:0]    vote_voter_i = '0;
    logic [CW-1:0]    vote_cand_i = '0;
    logic             accept_o, reject_o, busy_o, done_o, tie_o;
    logic [CW-1:0]    winner_o;
    logic [NC*TW-1:0] tally_o;

    int checks = 0;
    int errors = 0;

    int m_tally[NC];
    bit m_mask[NV];
    bit m_open;

    voting_session_ctrl dut (
        .clk(clk), .rst_n(rst_n), .open_i(open_i), .close_i(close_i),
        .vote_valid_i(vote_valid_i), .vote_voter_i(vote_voter_i), .vote_cand_i(vote_cand_i),
        .accept_o(accept_o), .reject_o(reject_o), .busy_o(busy_o), .done_o(done_o),
        .winner_o(winner_o), .tie_o(tie_o), .tally_o(tally_o)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running, required finish");
        $fatal(1);
    end

    function automatic logic [NC*TW-1:0] exp_tally();
        logic [NC*TW-1:0] r;
        r = '0;
        for (int k = 0; k < NC; k++) r[k*TW +: TW] = TW'(m_tally[k]);
        return r;
    endfunction

    function automatic logic [CW-1:0] exp_winner();
        int mx = -1;
        int w = 0;
        for (int k = 0; k < NC; k++) if (m_tally[k] > mx) begin mx = m_tally[k]; w = k; end
        return CW'(w);
    endfunction

    function automatic logic exp_tie();
        int mx = 0;
        int n = 0;
        for (int k = 0; k < NC; k++) if (m_tally[k] > mx) mx = m_tally[k];
        for (int k = 0; k < NC; k++) if (m_tally[k] == mx) n++;
        return (n > 1);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int k = 0; k < NC; k++) m_tally[k] = 0;
        for (int v = 0; v < NV; v++) m_mask[v] = 1'b0;
    endtask

    task automatic open_sess();
        open_i = 1'b1;
        tick();
        open_i = 1'b0;
        model_clear();
        m_open = 1'b1;
    endtask

    task automatic vote(input int v, input int c, input bit with_close,
                        output logic acc, output logic rej, output logic ea);
        ea = m_open && !m_mask[v] && (c < NC);
        vote_valid_i = 1'b1;
        vote_voter_i = VW'(v);
        vote_cand_i  = CW'(c);
        close_i      = with_close;
        tick();
        vote_valid_i = 1'b0;
        close_i      = 1'b0;
        acc = accept_o;
        rej = reject_o;
        if (ea) begin
            m_tally[c]++;
            m_mask[v] = 1'b1;
        end
        if (with_close && m_open) m_open = 1'b0;
    endtask

    task automatic wait_done(input int start, output int lat);
        lat = start;
        while (done_o !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic close_and_wait(output int lat);
        close_i = 1'b1;
        tick();
        close_i = 1'b0;
        m_open = 1'b0;
        wait_done(1, lat);
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({accept_o, reject_o, busy_o, done_o, winner_o, tie_o, tally_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got acc=%b rej=%b busy=%b done=%b win=%0d tie=%b tally=%h, required all 0",
                     accept_o, reject_o, busy_o, done_o, winner_o, tie_o, tally_o);
        end
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        model_clear();
        m_open = 1'b0;
    endtask

    task automatic test_idle_activity();
        logic acc, rej, ea;
        vote(1, 1, 1'b0, acc, rej, ea);
        checks++;
        if (acc !== 1'b0 || rej !== 1'b1 || tally_o !== '0) begin
            errors++;
            $display("FAIL idle_vote: got acc=%b rej=%b tally=%h, required acc=0 rej=1 tally=0", acc, rej, tally_o);
        end
        close_i = 1'b1;
        tick();
        close_i = 1'b0;
        tick();
        checks++;
        if (busy_o !== 1'b0 || done_o !== 1'b0) begin
            errors++;
            $display("FAIL idle_close: got busy=%b done=%b, required 0 0", busy_o, done_o);
        end
    endtask

    task automatic test_clear_winner();
        logic acc, rej, ea;
        int lat;
        int vs[4] = '{0, 1, 2, 3};
        int cs[4] = '{1, 1, 0, 2};
        open_sess();
        checks++;
        if (busy_o !== 1'b1 || done_o !== 1'b0 || tally_o !== '0 || tie_o !== 1'b0) begin
            errors++;
            $display("FAIL open_state: got busy=%b done=%b tally=%h tie=%b, required 1 0 0 0", busy_o, done_o, tally_o, tie_o);
        end
        for (int i = 0; i < 4; i++) begin
            vote(vs[i], cs[i], 1'b0, acc, rej, ea);
            checks++;
            if (acc !== 1'b1 || rej !== 1'b0 || tally_o !== exp_tally()) begin
                errors++;
                $display("FAIL clear_vote%0d: got acc=%b rej=%b tally=%h, required acc=1 rej=0 tally=%h", i, acc, rej, tally_o, exp_tally());
            end
        end
        close_and_wait(lat);
        checks++;
        if (lat !== NC + 1 || tally_o !== 9'b001_010_001 || winner_o !== 2'd1 || tie_o !== 1'b0) begin
            errors++;
            $display("FAIL clear_result: got lat=%0d tally=%h win=%0d tie=%b, required lat=%0d tally=051 win=1 tie=0", lat, tally_o, winner_o, tie_o, NC + 1);
        end
    endtask

    task automatic test_done_vote();
        logic acc, rej, ea;
        vote(0, 0, 1'b0, acc, rej, ea);
        checks++;
        if (acc !== 1'b0 || rej !== 1'b1 || tally_o !== exp_tally() || done_o !== 1'b1) begin
            errors++;
            $display("FAIL done_vote: got acc=%b rej=%b tally=%h done=%b, required acc=0 rej=1 tally=%h done=1", acc, rej, tally_o, exp_tally(), done_o);
        end
    endtask

    task automatic test_dup_invalid();
        logic acc, rej, ea;
        int lat;
        int vs[5] = '{2, 2, 1, 1, 2};
        int cs[5] = '{0, 1, 3, 1, 2};
        open_sess();
        for (int i = 0; i < 5; i++) begin
            vote(vs[i], cs[i], 1'b0, acc, rej, ea);
            checks++;
            if (acc !== ea || rej !== !ea || tally_o !== exp_tally()) begin
                errors++;
                $display("FAIL dup_vote%0d v%0d c%0d: got acc=%b rej=%b tally=%h, required acc=%b rej=%b tally=%h",
                         i, vs[i], cs[i], acc, rej, tally_o, ea, !ea, exp_tally());
            end
        end
        close_and_wait(lat);
    endtask

    task automatic test_tie_empty();
        logic acc, rej, ea;
        int lat;
        open_sess();
        vote(0, 0, 1'b0, acc, rej, ea);
        vote(1, 2, 1'b0, acc, rej, ea);
        close_and_wait(lat);
        checks++;
        if (lat !== NC + 1 || tie_o !== 1'b1 || winner_o !== 2'd0) begin
            errors++;
            $display("FAIL tie_result: got lat=%0d tie=%b win=%0d, required lat=%0d tie=1 win=0", lat, tie_o, winner_o, NC + 1);
        end
        open_sess();
        close_and_wait(lat);
        checks++;
        if (lat !== NC + 1 || tally_o !== '0 || tie_o !== 1'b1 || winner_o !== 2'd0) begin
            errors++;
            $display("FAIL empty_result: got lat=%0d tally=%h tie=%b win=%0d, required lat=%0d tally=0 tie=1 win=0", lat, tally_o, tie_o, winner_o, NC + 1);
        end
    endtask

    task automatic test_close_coincident();
        logic acc, rej, ea;
        int lat;
        open_sess();
        vote(3, 2, 1'b1, acc, rej, ea);
        checks++;
        if (acc !== 1'b1 || rej !== 1'b0 || tally_o !== 9'b001_000_000 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL coincident_vote: got acc=%b rej=%b tally=%h busy=%b, required acc=1 rej=0 tally=040 busy=1", acc, rej, tally_o, busy_o);
        end
        wait_done(1, lat);
        checks++;
        if (lat !== NC + 1 || winner_o !== 2'd2 || tie_o !== 1'b0) begin
            errors++;
            $display("FAIL coincident_result: got lat=%0d win=%0d tie=%b, required lat=%0d win=2 tie=0", lat, winner_o, tie_o, NC + 1);
        end
    endtask

    task automatic test_open_in_open();
        logic acc, rej, ea;
        int lat;
        open_sess();
        vote(0, 1, 1'b0, acc, rej, ea);
        open_i = 1'b1;
        tick();
        open_i = 1'b0;
        checks++;
        if (tally_o !== 9'b000_001_000 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL open_in_open: got tally=%h busy=%b, required tally=008 busy=1", tally_o, busy_o);
        end
        vote(0, 2, 1'b0, acc, rej, ea);
        checks++;
        if (acc !== 1'b0 || rej !== 1'b1) begin
            errors++;
            $display("FAIL open_mask_kept: got acc=%b rej=%b, required acc=0 rej=1", acc, rej);
        end
        close_and_wait(lat);
    endtask

    task automatic test_reset_mid_tally();
        logic acc, rej, ea;
        int lat;
        open_sess();
        vote(0, 2, 1'b0, acc, rej, ea);
        vote(1, 2, 1'b0, acc, rej, ea);
        close_i = 1'b1;
        tick();
        close_i = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({accept_o, reject_o, busy_o, done_o, winner_o, tie_o, tally_o} !== '0) begin
            errors++;
            $display("FAIL reset_mid_tally: got acc=%b rej=%b busy=%b done=%b win=%0d tie=%b tally=%h, required all 0",
                     accept_o, reject_o, busy_o, done_o, winner_o, tie_o, tally_o);
        end
        tick();
        rst_n = 1'b1;
        tick();
        model_clear();
        m_open = 1'b0;
        vote(0, 0, 1'b0, acc, rej, ea);
        checks++;
        if (acc !== 1'b0 || rej !== 1'b1 || busy_o !== 1'b0 || done_o !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_idle: got acc=%b rej=%b busy=%b done=%b, required 0 1 0 0", acc, rej, busy_o, done_o);
        end
        open_sess();
        vote(0, 2, 1'b0, acc, rej, ea);
        vote(1, 0, 1'b0, acc, rej, ea);
        vote(2, 2, 1'b0, acc, rej, ea);
        close_and_wait(lat);
        checks++;
        if (lat !== NC + 1 || tally_o !== exp_tally() || winner_o !== 2'd2 || tie_o !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_session: got lat=%0d tally=%h win=%0d tie=%b, required lat=%0d tally=%h win=2 tie=0",
                     lat, tally_o, winner_o, tie_o, NC + 1, exp_tally());
        end
    endtask

    task automatic test_random();
        logic acc, rej, ea;
        int lat, n, v, c;
        for (int s = 0; s < 12; s++) begin
            open_sess();
            n = $urandom_range(0, 8);
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 3) != 0) begin
                    v = $urandom_range(0, NV - 1);
                    c = $urandom_range(0, 3);
                    vote(v, c, 1'b0, acc, rej, ea);
                    checks++;
                    if (acc !== ea || rej !== !ea || tally_o !== exp_tally()) begin
                        errors++;
                        $display("FAIL rand_vote s%0d v%0d c%0d: got acc=%b rej=%b tally=%h, required acc=%b rej=%b tally=%h",
                                 s, v, c, acc, rej, tally_o, ea, !ea, exp_tally());
                    end
                end else begin
                    tick();
                    checks++;
                    if (accept_o !== 1'b0 || reject_o !== 1'b0) begin
                        errors++;
                        $display("FAIL rand_idle s%0d: got acc=%b rej=%b, required 0 0", s, accept_o, reject_o);
                    end
                end
            end
            close_and_wait(lat);
            checks++;
            if (lat !== NC + 1 || tally_o !== exp_tally() || winner_o !== exp_winner() || tie_o !== exp_tie()) begin
                errors++;
                $display("FAIL rand_result s%0d: got lat=%0d tally=%h win=%0d tie=%b, required lat=%0d tally=%h win=%0d tie=%b",
                         s, lat, tally_o, winner_o, tie_o, NC + 1, exp_tally(), exp_winner(), exp_tie());
            end
        end
    endtask

    initial begin
        test_reset();
        test_idle_activity();
        test_clear_winner();
        test_done_vote();
        test_dup_invalid();
        test_tie_empty();
        test_close_coincident();
        test_open_in_open();
        test_reset_mid_tally();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
